// File: rtl/writer.sv
// Streams one NDWORDS-dword record into Avalon-MM memory as little-endian halfword beats.
// First beat one cycle after accept, odone 2*NDWORDS+1 cycles after accept; waitrequest freezes the beat in flight.
module writer #(
  parameter int NDWORDS = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            baseaddr,
  input  logic [31:0]            index,
  input  logic                   write,
  input  logic [32*NDWORDS-1:0]  data,
  output logic                   iready,
  output logic                   odone,
  output logic                   avm_m0_write,
  output logic [31:0]            avm_m0_address,
  output logic [15:0]            avm_m0_writedata,
  output logic [1:0]             avm_m0_byteenable,
  input  logic                   avm_m0_waitrequest
);

  localparam int NBEATS = 2 * NDWORDS;
  localparam int BW = $clog2(NBEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);
  localparam logic [31:0] REC_BYTES = 32'(NDWORDS * 4);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                state, next_state;
  logic [BW-1:0]         beat;
  logic [32*NDWORDS-1:0] pend_q;
  logic                  accept;
  logic                  beat_acc;
  logic                  last_acc;

  assign accept   = write && iready;
  assign beat_acc = avm_m0_write && !avm_m0_waitrequest;
  assign last_acc = beat_acc && (beat == LAST_BEAT);
  assign avm_m0_byteenable = 2'b11;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    iready     = 1'b0;
    odone      = 1'b0;
    case (state)
      IDLE: begin
        iready = 1'b1;
        if (write) next_state = WRITE;
      end
      WRITE: begin
        if (last_acc) next_state = DONE;
      end
      DONE: begin
        odone      = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // pend_q holds the halfwords not yet presented; it shifts down one halfword per accepted beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat             <= '0;
      pend_q           <= '0;
      avm_m0_write     <= 1'b0;
      avm_m0_address   <= '0;
      avm_m0_writedata <= '0;
    end else if (accept) begin
      beat             <= '0;
      pend_q           <= data >> 16;
      avm_m0_write     <= 1'b1;
      avm_m0_address   <= baseaddr + index * REC_BYTES;
      avm_m0_writedata <= data[15:0];
    end else if (beat_acc) begin
      beat             <= beat + BW'(1);
      pend_q           <= pend_q >> 16;
      avm_m0_address   <= avm_m0_address + 32'd2;
      avm_m0_writedata <= pend_q[15:0];
      if (last_acc) avm_m0_write <= 1'b0;
    end
  end

endmodule

// File: tb/tb_writer.sv
// Directed bench for writer: a queue-based reference model checked every cycle plus literal expectations.
module tb_writer;

  localparam int NDW = 3;
  localparam int NB  = 2 * NDW;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [31:0]       baseaddr = '0;
  logic [31:0]       index = '0;
  logic              write = 1'b0;
  logic [32*NDW-1:0] data = '0;
  logic              iready;
  logic              odone;
  logic              avm_m0_write;
  logic [31:0]       avm_m0_address;
  logic [15:0]       avm_m0_writedata;
  logic [1:0]        avm_m0_byteenable;
  logic              avm_m0_waitrequest = 1'b0;

  writer #(.NDWORDS(NDW)) dut (
    .clk                (clk),
    .reset              (reset),
    .baseaddr           (baseaddr),
    .index              (index),
    .write              (write),
    .data               (data),
    .iready             (iready),
    .odone              (odone),
    .avm_m0_write       (avm_m0_write),
    .avm_m0_address     (avm_m0_address),
    .avm_m0_writedata   (avm_m0_writedata),
    .avm_m0_byteenable  (avm_m0_byteenable),
    .avm_m0_waitrequest (avm_m0_waitrequest)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int beats_acc = 0;
  int odone_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each accepted record becomes a queue of expected beats.
  typedef struct {
    logic [31:0] a;
    logic [15:0] d;
  } beat_t;

  beat_t q[$];
  bit    busy = 0;
  bit    odone_due = 0;

  task automatic push_record(input logic [31:0] ba, input logic [31:0] idx, input logic [32*NDW-1:0] d);
    logic [31:0] a0;
    beat_t bt;
    a0 = ba + idx * 32'(NDW * 4);
    for (int b = 0; b < NB; b++) begin
      bt.a = a0 + 32'(2 * b);
      bt.d = d[16*b +: 16];
      q.push_back(bt);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_write"}, 32'(avm_m0_write), 32'd0);
    chk({tag, "_addr"}, avm_m0_address, 32'd0);
    chk({tag, "_wdata"}, 32'(avm_m0_writedata), 32'd0);
    chk({tag, "_odone"}, 32'(odone), 32'd0);
    chk({tag, "_iready"}, 32'(iready), 32'd1);
  endtask

  initial begin
    forever begin
      @(negedge clk or posedge reset);
      if (reset) begin
        #1;
        check_reset_vals("m_rst");
        q.delete();
        busy = 0;
        odone_due = 0;
      end else begin
        bit exp_w;
        bit cur_ready;
        exp_w = (q.size() > 0);
        cur_ready = !busy;
        chk("m_write", 32'(avm_m0_write), 32'(exp_w));
        if (exp_w) begin
          chk("m_addr", avm_m0_address, q[0].a);
          chk("m_wdata", 32'(avm_m0_writedata), 32'(q[0].d));
        end
        chk("m_byteen", 32'(avm_m0_byteenable), 32'd3);
        chk("m_odone", 32'(odone), 32'(odone_due));
        chk("m_iready", 32'(iready), 32'(cur_ready));
        if (odone === 1'b1) odone_cnt++;
        if (odone_due) begin
          busy = 0;
          odone_due = 0;
        end
        if (exp_w && !avm_m0_waitrequest) begin
          void'(q.pop_front());
          beats_acc++;
          if (q.size() == 0) odone_due = 1;
        end
        if (write && cur_ready) begin
          push_record(baseaddr, index, data);
          busy = 1;
        end
      end
    end
  end

  // Caller sits just after a rising edge; returns just after the accept edge (start of cycle 1).
  task automatic start_rec(input logic [31:0] ba, input logic [31:0] idx, input logic [32*NDW-1:0] d);
    baseaddr = ba;
    index    = idx;
    data     = d;
    write    = 1'b1;
    @(negedge clk);
    chk("accept_iready", 32'(iready), 32'd1);
    @(posedge clk);
    #2;
    write    = 1'b0;
    data     = ~d;
    baseaddr = 32'hDEAD_0000;
    index    = 32'h77;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  logic [32*NDW-1:0] rec;
  logic [15:0] hw_tab [0:5];
  int b0, o0, bidx;

  initial begin
    rec = {32'h12345678, 32'hAAAA5555, 32'h00010002};
    hw_tab[0] = 16'h0002; hw_tab[1] = 16'h0001; hw_tab[2] = 16'h5555;
    hw_tab[3] = 16'hAAAA; hw_tab[4] = 16'h5678; hw_tab[5] = 16'h1234;

    next_cycle();
    @(negedge clk);
    check_reset_vals("por");
    next_cycle();
    reset = 1'b0;

    // basic record, first accept on the first edge after reset release
    start_rec(32'h1000, 32'd2, rec);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c <= 6) begin
        chk("s1_write", 32'(avm_m0_write), 32'd1);
        chk("s1_addr", avm_m0_address, 32'h1018 + 32'(2 * (c - 1)));
        chk("s1_wdata", 32'(avm_m0_writedata), 32'(hw_tab[c-1]));
        chk("s1_iready", 32'(iready), 32'd0);
      end
      if (c == 7) begin
        chk("s1_odone", 32'(odone), 32'd1);
        chk("s1_write_off", 32'(avm_m0_write), 32'd0);
      end
      if (c == 8) chk("s1_iready_back", 32'(iready), 32'd1);
      next_cycle();
    end

    // waitrequest held for 3 cycles on beat 2
    start_rec(32'h1000, 32'd2, rec);
    for (int c = 1; c <= 11; c++) begin
      avm_m0_waitrequest = (c >= 3 && c <= 5);
      @(negedge clk);
      bidx = (c <= 3) ? c - 1 : ((c <= 6) ? 2 : c - 4);
      if (c <= 9) begin
        chk("s2_write", 32'(avm_m0_write), 32'd1);
        chk("s2_addr", avm_m0_address, 32'h1018 + 32'(2 * bidx));
        chk("s2_wdata", 32'(avm_m0_writedata), 32'(hw_tab[bidx]));
      end
      chk("s2_odone", 32'(odone), 32'(c == 10));
      if (c == 11) chk("s2_iready", 32'(iready), 32'd1);
      next_cycle();
    end
    avm_m0_waitrequest = 1'b0;

    // write held high across two records
    baseaddr = 32'h0;
    index    = 32'd0;
    data     = rec;
    write    = 1'b1;
    @(negedge clk);
    chk("s3_accept0", 32'(iready), 32'd1);
    next_cycle();
    index = 32'd1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c <= 7) chk("s3_busy", 32'(iready), 32'd0);
      if (c == 8) chk("s3_accept1", 32'(iready), 32'd1);
      if (c == 1) chk("s3_addr_r0", avm_m0_address, 32'h0000);
      if (c == 9) chk("s3_addr_r1", avm_m0_address, 32'h000C);
      if (c == 14) chk("s3_addr_r1_last", avm_m0_address, 32'h0016);
      if (c == 15) chk("s3_odone_r1", 32'(odone), 32'd1);
      if (c == 16) chk("s3_iready_end", 32'(iready), 32'd1);
      next_cycle();
      if (c == 8) write = 1'b0;
    end

    // address wrap at the top of the 32-bit space
    start_rec(32'hFFFF_FFF8, 32'd0, rec);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c <= 6) chk("s4_addr", avm_m0_address, 32'hFFFF_FFF8 + 32'(2 * (c - 1)));
      next_cycle();
    end

    // reset pulse mid-record after beat 3 has been accepted
    start_rec(32'h2000, 32'd1, rec);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      next_cycle();
    end
    reset = 1'b1;
    #1;
    chk("s5_write_drop", 32'(avm_m0_write), 32'd0);
    chk("s5_iready", 32'(iready), 32'd1);
    chk("s5_odone", 32'(odone), 32'd0);
    #1;
    reset = 1'b0;
    for (int c = 5; c <= 9; c++) begin
      @(negedge clk);
      chk("s5_no_odone", 32'(odone), 32'd0);
      chk("s5_no_write", 32'(avm_m0_write), 32'd0);
      next_cycle();
    end
    start_rec(32'h2000, 32'd3, rec);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("s5_restart_addr", avm_m0_address, 32'h2024);
        chk("s5_restart_wdata", 32'(avm_m0_writedata), 32'h0002);
      end
      next_cycle();
    end

    // stray write pulses during WRITE and DONE must be ignored
    b0 = beats_acc;
    o0 = odone_cnt;
    start_rec(32'h3000, 32'd0, rec);
    for (int c = 1; c <= 8; c++) begin
      write = (c == 3 || c == 7);
      index = 32'd5;
      @(negedge clk);
      next_cycle();
    end
    write = 1'b0;
    repeat (3) begin
      @(negedge clk);
      next_cycle();
    end
    chk("s6_beats", 32'(beats_acc - b0), 32'd6);
    chk("s6_odones", 32'(odone_cnt - o0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
